// File: rtl/spi_master_mcs.sv
// Multi-chip-select SPI master: one shift engine, per-transaction mode, length, divider and CS hold.
// Requests are accepted in IDLE or HELD; o_done pulses as the word completes.
module spi_master_mcs #(
  parameter  int SPI_CLOCK_DIVIDER_WIDTH = 5,
  parameter  int SPI_DATA_WIDTH          = 32,
  parameter  int CS_COUNT                = 4,
  localparam int CS_SEL_WIDTH            = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1,
  localparam int BIT_COUNT_WIDTH         = $clog2(SPI_DATA_WIDTH + 1)
) (
  input  logic                               i_clock,
  input  logic                               i_reset,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [CS_SEL_WIDTH-1:0]            i_cs_select,
  input  logic [BIT_COUNT_WIDTH-1:0]         i_bit_count,
  input  logic                               i_hold_cs,
  input  logic                               i_clock_polarity,
  input  logic                               i_clock_phase,
  input  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] i_spi_clock_divider,
  input  logic [SPI_DATA_WIDTH-1:0]          i_data_in,
  output logic [SPI_DATA_WIDTH-1:0]          o_data_out,
  output logic                               o_done,
  output logic                               o_busy,
  output logic [CS_COUNT-1:0]                o_spi_cs_n,
  output logic                               o_spi_clock,
  output logic                               o_spi_mosi,
  input  logic                               i_spi_miso
);

  localparam int DW = SPI_DATA_WIDTH;
  localparam int CW = SPI_CLOCK_DIVIDER_WIDTH;
  localparam int BW = BIT_COUNT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_HELD, S_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_en_q;
  logic [CS_SEL_WIDTH-1:0] cs_sel_q;
  logic                    cpol_q, cpha_q, hold_q, pend_q;
  logic [CW-1:0]           div_q, hp_cnt_q;
  logic [BW-1:0]           n_q, bit_cnt_q;
  logic                    phase_q, sample_q;
  logic [DW-1:0]           tx_q, rx_q, data_out_q;
  logic                    done_q, sclk_q, mosi_q, miso_s1, miso_s2;
  logic                    cs_active;

  logic          accept, hp_last, last_bit, spi_edge, same_mode;
  logic [BW-1:0] n_in;
  logic [CW-1:0] div_in;
  logic [DW-1:0] aligned;

  assign accept    = i_valid && o_ready;
  assign hp_last   = (hp_cnt_q == div_q - CW'(1));
  assign last_bit  = (bit_cnt_q == n_q);
  assign spi_edge  = hp_last && ((state_q == S_SETUP) || (state_q == S_SHIFT && !last_bit));
  assign same_mode = (i_cs_select == cs_sel_q) && (i_clock_polarity == cpol_q) &&
                     (i_clock_phase == cpha_q);
  assign n_in      = (i_bit_count == '0) ? BW'(DW) : i_bit_count;
  assign div_in    = (i_spi_clock_divider == '0) ? CW'(1) : i_spi_clock_divider;
  // Left-align the word so the next MOSI bit is always the MSB of tx_q.
  assign aligned   = i_data_in << (BW'(DW) - n_in);

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept)  state_d = S_SETUP;
      S_SETUP:   if (hp_last) state_d = S_SHIFT;
      S_SHIFT:   if (hp_last && last_bit) state_d = S_HOLD;
      S_HOLD:    if (hp_last) state_d = hold_q ? S_HELD : S_GAP;
      S_GAP:     if (hp_last) state_d = pend_q ? S_SETUP : S_IDLE;
      S_HELD:    if (accept)  state_d = same_mode ? S_SETUP : S_RELEASE;
      S_RELEASE: state_d = S_GAP;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    cs_active = 1'b0;
    case (state_q)
      S_IDLE:                  o_ready = ready_en_q;
      S_HELD:                  begin o_ready = ready_en_q; cs_active = 1'b1; end
      S_SETUP, S_SHIFT, S_HOLD: begin o_busy = 1'b1; cs_active = 1'b1; end
      default:                 o_busy = 1'b1;
    endcase
    o_spi_cs_n = '1;
    for (int i = 0; i < CS_COUNT; i++)
      if (cs_active && cs_sel_q == CS_SEL_WIDTH'(i)) o_spi_cs_n[i] = 1'b0;
  end

  assign o_spi_clock = sclk_q;
  assign o_spi_mosi  = mosi_q;
  assign o_data_out  = data_out_q;
  assign o_done      = done_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ready_en_q <= 1'b0;  cs_sel_q <= '0;   cpol_q <= 1'b0;   cpha_q <= 1'b0;
      hold_q     <= 1'b0;  pend_q   <= 1'b0; div_q  <= CW'(1); hp_cnt_q <= '0;
      n_q        <= '0;    bit_cnt_q <= '0;  phase_q <= 1'b0;  sample_q <= 1'b0;
      tx_q       <= '0;    rx_q     <= '0;   data_out_q <= '0; done_q <= 1'b0;
      sclk_q     <= 1'b0;  mosi_q   <= 1'b0; miso_s1 <= 1'b0;  miso_s2 <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      miso_s1    <= i_spi_miso;
      miso_s2    <= miso_s1;
      done_q     <= 1'b0;
      sample_q   <= 1'b0;
      if (state_q inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP} && !hp_last)
        hp_cnt_q <= hp_cnt_q + CW'(1);
      else
        hp_cnt_q <= '0;
      // Capture one cycle after the sampling edge to absorb the MISO synchroniser delay.
      if (sample_q) rx_q <= {rx_q[DW-2:0], miso_s2};

      if (accept) begin
        cs_sel_q  <= i_cs_select;
        cpol_q    <= i_clock_polarity;
        cpha_q    <= i_clock_phase;
        hold_q    <= i_hold_cs;
        div_q     <= div_in;
        n_q       <= n_in;
        pend_q    <= (state_q == S_HELD) && !same_mode;
        bit_cnt_q <= '0;
        phase_q   <= 1'b0;
        rx_q      <= '0;
        sclk_q    <= i_clock_polarity;
        if (i_clock_phase) begin
          tx_q <= aligned;
        end else begin
          mosi_q <= aligned[DW-1];
          tx_q   <= aligned << 1;
        end
      end else if (spi_edge) begin
        sclk_q <= ~sclk_q;
        if (!phase_q) begin
          phase_q <= 1'b1;
          if (cpha_q) begin
            mosi_q <= tx_q[DW-1];
            tx_q   <= tx_q << 1;
          end else begin
            sample_q <= 1'b1;
          end
        end else begin
          phase_q   <= 1'b0;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          if (cpha_q) begin
            sample_q <= 1'b1;
          end else if (bit_cnt_q != n_q - BW'(1)) begin
            mosi_q <= tx_q[DW-1];
            tx_q   <= tx_q << 1;
          end
        end
      end

      if (state_q == S_HOLD && hp_last) begin
        data_out_q <= rx_q;
        done_q     <= 1'b1;
      end
      if (state_q == S_GAP && hp_last) pend_q <= 1'b0;
    end
  end

endmodule
